// File: rtl/riscv_core_div.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and their W forms.
// Divides operand magnitudes one quotient bit per cycle, then fixes up sign and width on the final step.
module riscv_core_div #(
  parameter int XLEN = 64
) (
  input  logic            i_div_clk,
  input  logic            i_div_rst_n,
  input  logic            i_div_valid,
  output logic            o_div_ready,
  input  logic [1:0]      i_div_op,
  input  logic            i_div_word,
  input  logic [XLEN-1:0] i_div_rs1,
  input  logic [XLEN-1:0] i_div_rs2,
  input  logic [4:0]      i_div_rd,
  input  logic            i_div_flush,
  output logic            o_div_valid,
  input  logic            i_div_ack,
  output logic [XLEN-1:0] o_div_result,
  output logic [4:0]      o_div_rd,
  output logic            o_div_busy
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [1:0]      op;
  logic            word;
  logic            qneg, rneg;
  logic [XLEN-1:0] quo, rem, dvs;
  logic [CW-1:0]   count;

  logic            sgn_in, a_neg, b_neg, div_zero, overflow;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, quo_load, special_q, special_r;
  logic [XLEN:0]   rem_sh, rem_sub;
  logic [XLEN-1:0] rem_nxt, quo_nxt, fin;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  // Operand preparation and special-case detection on the incoming request.
  always_comb begin
    sgn_in = ~i_div_op[0];
    if (i_div_word) begin
      a_ext = sgn_in ? sext32(i_div_rs1[31:0]) : {{(XLEN-32){1'b0}}, i_div_rs1[31:0]};
      b_ext = sgn_in ? sext32(i_div_rs2[31:0]) : {{(XLEN-32){1'b0}}, i_div_rs2[31:0]};
    end else begin
      a_ext = i_div_rs1;
      b_ext = i_div_rs2;
    end
    a_neg    = sgn_in & a_ext[XLEN-1];
    b_neg    = sgn_in & b_ext[XLEN-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    div_zero = (b_ext == '0);
    overflow = sgn_in && (b_ext == '1) &&
               (a_ext == (i_div_word ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}}));
    // W forms park the 32-bit dividend at the top so the MSB is consumed first.
    quo_load  = i_div_word ? (a_mag << (XLEN-32)) : a_mag;
    special_q = div_zero ? '1 : a_ext;
    special_r = div_zero ? (i_div_word ? sext32(i_div_rs1[31:0]) : i_div_rs1) : '0;
  end

  // One restoring step plus the sign/width fix-up used on the last step.
  always_comb begin
    rem_sh  = {rem, quo[XLEN-1]};
    rem_sub = rem_sh - {1'b0, dvs};
    if (!rem_sub[XLEN]) begin
      rem_nxt = rem_sub[XLEN-1:0];
      quo_nxt = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_nxt = rem_sh[XLEN-1:0];
      quo_nxt = {quo[XLEN-2:0], 1'b0};
    end
    fin = op[1] ? rem_nxt : quo_nxt;
    if (!op[0] && (op[1] ? rneg : qneg)) fin = -fin;
    if (word) fin = sext32(fin[31:0]);
  end

  always_ff @(posedge i_div_clk or negedge i_div_rst_n) begin
    if (!i_div_rst_n) begin
      state        <= IDLE;
      op           <= '0;
      word         <= 1'b0;
      qneg         <= 1'b0;
      rneg         <= 1'b0;
      quo          <= '0;
      rem          <= '0;
      dvs          <= '0;
      count        <= '0;
      o_div_valid  <= 1'b0;
      o_div_result <= '0;
      o_div_rd     <= '0;
    end else if (i_div_flush) begin
      state       <= IDLE;
      o_div_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_div_valid) begin
          op       <= i_div_op;
          word     <= i_div_word;
          o_div_rd <= i_div_rd;
          qneg     <= a_neg ^ b_neg;
          rneg     <= a_neg;
          if (div_zero || overflow) begin
            o_div_result <= i_div_op[1] ? special_r : special_q;
            o_div_valid  <= 1'b1;
            state        <= DONE;
          end else begin
            rem   <= '0;
            quo   <= quo_load;
            dvs   <= b_mag;
            count <= i_div_word ? CW'(32) : CW'(XLEN);
            state <= CALC;
          end
        end
        CALC: begin
          rem   <= rem_nxt;
          quo   <= quo_nxt;
          count <= count - 1'b1;
          if (count == CW'(1)) begin
            o_div_result <= fin;
            o_div_valid  <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: if (i_div_ack) begin
          o_div_valid <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_div_ready = (state == IDLE);
  assign o_div_busy  = (state != IDLE);

endmodule

// File: tb/tb_riscv_core_div.sv
// Self-checking bench for riscv_core_div: directed vectors, randomized ops against an
// arithmetic reference model, backpressure, flush and mid-operation reset.
module tb_riscv_core_div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [1:0]  i_op = '0;
  logic        i_word = 1'b0;
  logic [63:0] i_rs1 = '0;
  logic [63:0] i_rs2 = '0;
  logic [4:0]  i_rd = '0;
  logic        i_flush = 1'b0;
  logic        o_valid;
  logic        i_ack = 1'b0;
  logic [63:0] o_result;
  logic [4:0]  o_rd;
  logic        o_busy;

  int passed = 0;
  int total = 0;

  riscv_core_div #(.XLEN(64)) dut (
    .i_div_clk(clk), .i_div_rst_n(rst_n), .i_div_valid(i_valid), .o_div_ready(o_ready),
    .i_div_op(i_op), .i_div_word(i_word), .i_div_rs1(i_rs1), .i_div_rs2(i_rs2),
    .i_div_rd(i_rd), .i_div_flush(i_flush), .o_div_valid(o_valid), .i_div_ack(i_ack),
    .o_div_result(o_result), .o_div_rd(o_rd), .o_div_busy(o_busy)
  );

  always #5 clk = ~clk;

  // Reference: plain language-level division with the RISC-V special cases.
  function automatic logic [63:0] ref_div(input logic [1:0] op, input logic word,
                                          input logic [63:0] a, input logic [63:0] b);
    logic        sgn;
    logic [31:0] a32, b32, q32, r32;
    logic [63:0] q64, r64;
    sgn = (op[0] == 1'b0);
    if (word) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 32'd0) begin
        q32 = 32'hFFFF_FFFF; r32 = a32;
      end else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = 32'd0;
      end else if (sgn) begin
        q32 = $signed(a32) / $signed(b32);
        r32 = $signed(a32) % $signed(b32);
      end else begin
        q32 = a32 / b32;
        r32 = a32 % b32;
      end
      return op[1] ? {{32{r32[31]}}, r32} : {{32{q32[31]}}, q32};
    end
    if (b == 64'd0) begin
      q64 = '1; r64 = a;
    end else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin
      q64 = a; r64 = 64'd0;
    end else if (sgn) begin
      q64 = $signed(a) / $signed(b);
      r64 = $signed(a) % $signed(b);
    end else begin
      q64 = a / b;
      r64 = a % b;
    end
    return op[1] ? r64 : q64;
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic word,
                                 input logic [63:0] a, input logic [63:0] b);
    logic special;
    if (word)
      special = (b[31:0] == 0) || (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    else
      special = (b == 0) || (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1);
    return special ? 1 : (word ? 33 : 65);
  endfunction

  // Issues one request, waits (bounded) for the result, acks it immediately.
  task automatic run_op(input logic [1:0] op, input logic word, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd,
                        output logic [63:0] res, output logic [4:0] rd_o, output int lat);
    @(negedge clk);
    i_valid = 1'b1; i_op = op; i_word = word; i_rs1 = a; i_rs2 = b; i_rd = rd;
    @(negedge clk);
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    res = o_result;
    rd_o = o_rd;
    i_ack = 1'b1;
    @(negedge clk);
    i_ack = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++; if (o_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", o_valid); else passed++;
    total++; if (o_result !== 64'd0) $display("[TB] FAIL reset_result: got %h want 0", o_result); else passed++;
    total++; if (o_rd !== 5'd0) $display("[TB] FAIL reset_rd: got %0d want 0", o_rd); else passed++;
    total++; if (o_busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", o_busy); else passed++;
    total++; if (o_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b want 1", o_ready); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [1:0]  ops[8];
    logic        wds[8];
    logic [63:0] as[8], bs[8], exps[8];
    int          lats[8];
    logic [63:0] res;
    logic [4:0]  rd_o;
    int          lat;
    ops = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b00, 2'b10, 2'b01, 2'b10};
    wds = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    as  = '{64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9, 64'd100, 64'd100,
            64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0000_0000_8000_0000,
            64'hFFFF_FFFF_FFFF_FFF7};
    bs  = '{64'd2, 64'd2, 64'd0, 64'd0, '1, '1, 64'd1, 64'd4};
    exps = '{64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h64,
             64'h8000_0000_0000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
    lats = '{65, 65, 1, 1, 1, 1, 33, 33};
    for (int i = 0; i < 8; i++) begin
      run_op(ops[i], wds[i], as[i], bs[i], 5'(i + 3), res, rd_o, lat);
      total++; if (res !== exps[i]) $display("[TB] FAIL directed%0d_result: got %h want %h", i, res, exps[i]); else passed++;
      total++; if (lat !== lats[i]) $display("[TB] FAIL directed%0d_latency: got %0d want %0d", i, lat, lats[i]); else passed++;
      total++; if (rd_o !== 5'(i + 3)) $display("[TB] FAIL directed%0d_rd: got %0d want %0d", i, rd_o, i + 3); else passed++;
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic        word;
    logic [63:0] a, b, res, exp;
    logic [4:0]  rd, rd_o;
    int          lat, mode;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      word = 1'($urandom_range(0, 1));
      rd = 5'($urandom_range(0, 31));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      mode = $urandom_range(0, 7);
      if (mode == 0) b = word ? {$urandom, 32'd0} : 64'd0;
      else if (mode == 1) begin
        a = word ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
        b = word ? {$urandom, 32'hFFFF_FFFF} : '1;
      end else if (mode == 2) begin
        a = {{48{a[15]}}, a[15:0]};
        b = {{56{b[7]}}, b[7:0]};
      end
      exp = ref_div(op, word, a, b);
      run_op(op, word, a, b, rd, res, rd_o, lat);
      total++; if (res !== exp) $display("[TB] FAIL random%0d_result: op=%0d w=%b a=%h b=%h got %h want %h", i, op, word, a, b, res, exp); else passed++;
      total++; if (lat !== ref_lat(op, word, a, b)) $display("[TB] FAIL random%0d_latency: got %0d want %0d", i, lat, ref_lat(op, word, a, b)); else passed++;
      total++; if (rd_o !== rd) $display("[TB] FAIL random%0d_rd: got %0d want %0d", i, rd_o, rd); else passed++;
    end
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    i_valid = 1'b1; i_op = 2'b00; i_word = 1'b0; i_rs1 = 64'd1000; i_rs2 = 64'd7; i_rd = 5'd9;
    @(negedge clk);
    i_valid = 1'b0;
    n = 0;
    while (!o_valid && n < 200) begin @(negedge clk); n++; end
    total++; if (o_valid !== 1'b1) $display("[TB] FAIL bp_valid_timeout: got %b want 1", o_valid); else passed++;
    // A competing request while DONE must be ignored.
    i_valid = 1'b1; i_op = 2'b11; i_rs1 = 64'd55; i_rs2 = 64'd0; i_rd = 5'd21;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++; if (o_valid !== 1'b1 || o_result !== 64'd142 || o_rd !== 5'd9)
        $display("[TB] FAIL bp_hold%0d: got v=%b r=%h rd=%0d want v=1 r=8e rd=9", k, o_valid, o_result, o_rd);
      else passed++;
    end
    i_valid = 1'b0;
    i_ack = 1'b1;
    @(negedge clk);
    i_ack = 1'b0;
    total++; if (o_valid !== 1'b0) $display("[TB] FAIL bp_valid_after_ack: got %b want 0", o_valid); else passed++;
    total++; if (o_ready !== 1'b1) $display("[TB] FAIL bp_ready_after_ack: got %b want 1", o_ready); else passed++;
  endtask

  task automatic test_flush();
    logic [63:0] res;
    logic [4:0]  rd_o;
    int          lat;
    logic        seen;
    @(negedge clk);
    i_valid = 1'b1; i_op = 2'b00; i_word = 1'b0; i_rs1 = 64'd12345678; i_rs2 = 64'd3; i_rd = 5'd4;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (10) @(negedge clk);
    i_flush = 1'b1; i_valid = 1'b1; i_ack = 1'b1;
    @(negedge clk);
    i_flush = 1'b0; i_valid = 1'b0; i_ack = 1'b0;
    total++; if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_valid !== 1'b0)
      $display("[TB] FAIL flush_idle: got ready=%b busy=%b valid=%b want 1 0 0", o_ready, o_busy, o_valid);
    else passed++;
    seen = 1'b0;
    repeat (80) begin @(negedge clk); if (o_valid) seen = 1'b1; end
    total++; if (seen !== 1'b0) $display("[TB] FAIL flush_no_valid: got %b want 0", seen); else passed++;
    run_op(2'b01, 1'b0, 64'd12345678, 64'd3, 5'd6, res, rd_o, lat);
    total++; if (res !== 64'd4115226) $display("[TB] FAIL flush_recover: got %h want %h", res, 64'd4115226); else passed++;
  endtask

  task automatic test_reset_mid_calc();
    logic [63:0] res;
    logic [4:0]  rd_o;
    int          lat;
    logic        seen;
    @(negedge clk);
    i_valid = 1'b1; i_op = 2'b10; i_word = 1'b0; i_rs1 = 64'd999; i_rs2 = 64'd10; i_rd = 5'd17;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (o_valid !== 1'b0 || o_result !== 64'd0 || o_rd !== 5'd0 || o_busy !== 1'b0 || o_ready !== 1'b1)
      $display("[TB] FAIL midreset_outputs: got v=%b r=%h rd=%0d busy=%b ready=%b want 0 0 0 0 1",
               o_valid, o_result, o_rd, o_busy, o_ready);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (80) begin @(negedge clk); if (o_valid) seen = 1'b1; end
    total++; if (seen !== 1'b0) $display("[TB] FAIL midreset_no_valid: got %b want 0", seen); else passed++;
    run_op(2'b10, 1'b0, 64'd999, 64'd10, 5'd17, res, rd_o, lat);
    total++; if (res !== 64'd9) $display("[TB] FAIL midreset_recover: got %h want 9", res); else passed++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_flush();
    test_reset_mid_calc();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
